// File: rtl/canny_pkg.sv
// Shared types for the Canny pipeline: sequencer states, neighbour select
// codes, pixel type, and the helper that walks the neighbour fetch order.
package canny_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } gws_state_t;

    typedef enum logic [2:0] {
        NB_P5 = 3'd0,
        NB_P2 = 3'd1,
        NB_P4 = 3'd2,
        NB_P6 = 3'd3,
        NB_P8 = 3'd4
    } nb_sel_t;

    typedef logic [7:0] pixel_t;

    // Next in-image neighbour to fetch after 'cur' in the order p5,p2,p4,p6,p8.
    // NB_P5 is never a successor, so returning it means the window is complete.
    function automatic nb_sel_t next_nb(input nb_sel_t cur,
                                        input logic    row_first,
                                        input logic    row_last,
                                        input logic    col_first,
                                        input logic    col_last);
        nb_sel_t nxt;
        nxt = NB_P5;
        case (cur)
            NB_P5: begin
                if (!row_first)      nxt = NB_P2;
                else if (!col_first) nxt = NB_P4;
                else if (!col_last)  nxt = NB_P6;
                else if (!row_last)  nxt = NB_P8;
                else                 nxt = NB_P5;
            end
            NB_P2: begin
                if (!col_first)      nxt = NB_P4;
                else if (!col_last)  nxt = NB_P6;
                else if (!row_last)  nxt = NB_P8;
                else                 nxt = NB_P5;
            end
            NB_P4: begin
                if (!col_last)       nxt = NB_P6;
                else if (!row_last)  nxt = NB_P8;
                else                 nxt = NB_P5;
            end
            NB_P6: begin
                if (!row_last)       nxt = NB_P8;
                else                 nxt = NB_P5;
            end
            NB_P8:   nxt = NB_P5;
            default: nxt = NB_P5;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/gws_scan_counter.sv
// Row/column/centre-address scan counters for the gradient window sequencer.
// The centre address increments alongside the column so no multiplier is needed.
module gws_scan_counter #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 16,
    parameter int BASE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     adv,
    output logic [$clog2(IMG_H)-1:0] row,
    output logic [$clog2(IMG_W)-1:0] col,
    output logic [ADDR_W-1:0]        addr,
    output logic                     row_first,
    output logic                     row_last,
    output logic                     col_first,
    output logic                     col_last,
    output logic                     is_last
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    localparam logic [ROW_W-1:0]  ROW_ZERO = ROW_W'(0);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0]  COL_ZERO = COL_W'(0);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);

    logic [ROW_W-1:0]  row_r;
    logic [COL_W-1:0]  col_r;
    logic [ADDR_W-1:0] addr_r;

    assign row_first = (row_r == ROW_ZERO);
    assign row_last  = (row_r == ROW_MAX);
    assign col_first = (col_r == COL_ZERO);
    assign col_last  = (col_r == COL_MAX);
    assign is_last   = row_last && col_last;

    assign row  = row_r;
    assign col  = col_r;
    assign addr = addr_r;

    // Row-major scan: column wraps into the next row; never advances past the last pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r  <= ROW_ZERO;
            col_r  <= COL_ZERO;
            addr_r <= BASE_A;
        end else if (clr) begin
            row_r  <= ROW_ZERO;
            col_r  <= COL_ZERO;
            addr_r <= BASE_A;
        end else if (adv && !is_last) begin
            addr_r <= addr_r + ADDR_ONE;
            if (col_last) begin
                col_r <= COL_ZERO;
                row_r <= row_r + ROW_ONE;
            end else begin
                col_r <= col_r + COL_ONE;
            end
        end
    end

endmodule

// File: rtl/gradient_window_sequencer.sv
// Gradient-magnitude window sequencer: scans the image row-major, fetches the
// 5-point cross around each pixel from a req/ack memory (border neighbours
// replaced by the centre), and presents each window over valid/ready.
module gradient_window_sequencer
    import canny_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 16,
    parameter int BASE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ack,
    input  logic [7:0]               mem_rdata,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [7:0]               p2,
    output logic [7:0]               p4,
    output logic [7:0]               p5,
    output logic [7:0]               p6,
    output logic [7:0]               p8,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col
);

    localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

    gws_state_t        state_r, state_s;
    nb_sel_t           nb_r, nb_s, nxt_nb_s;
    logic              mem_req_r, mem_req_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic              win_valid_r, win_valid_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              cap_s, cnt_clr_s, cnt_adv_s;
    pixel_t            p2_r, p4_r, p5_r, p6_r, p8_r;

    logic [ADDR_W-1:0] cnt_addr_s;
    logic              row_first_s, row_last_s, col_first_s, col_last_s, is_last_s;

    gws_scan_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .BASE   (BASE)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr_s),
        .adv       (cnt_adv_s),
        .row       (win_row),
        .col       (win_col),
        .addr      (cnt_addr_s),
        .row_first (row_first_s),
        .row_last  (row_last_s),
        .col_first (col_first_s),
        .col_last  (col_last_s),
        .is_last   (is_last_s)
    );

    // Memory address of a cross neighbour relative to the centre address.
    function automatic logic [ADDR_W-1:0] nb_addr(input nb_sel_t sel, input logic [ADDR_W-1:0] c);
        logic [ADDR_W-1:0] a;
        case (sel)
            NB_P2:   a = c - W_A;
            NB_P4:   a = c - ONE_A;
            NB_P6:   a = c + ONE_A;
            NB_P8:   a = c + W_A;
            default: a = c;
        endcase
        return a;
    endfunction

    // Next-state and next-output logic; abort overrides every other event.
    always_comb begin
        state_s     = state_r;
        nb_s        = nb_r;
        mem_req_s   = mem_req_r;
        mem_addr_s  = mem_addr_r;
        win_valid_s = win_valid_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        cap_s       = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_adv_s   = 1'b0;
        nxt_nb_s    = next_nb(nb_r, row_first_s, row_last_s, col_first_s, col_last_s);
        if ((state_r != IDLE) && abort) begin
            state_s     = IDLE;
            mem_req_s   = 1'b0;
            win_valid_s = 1'b0;
            busy_s      = 1'b0;
            cnt_clr_s   = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s    = FETCH;
                        nb_s       = NB_P5;
                        mem_req_s  = 1'b1;
                        mem_addr_s = cnt_addr_s;
                        busy_s     = 1'b1;
                    end else begin
                        busy_s = 1'b0;
                    end
                end
                FETCH: begin
                    if (mem_req_r && mem_ack) begin
                        cap_s = 1'b1;
                        if (nxt_nb_s == NB_P5) begin
                            state_s     = PRESENT;
                            mem_req_s   = 1'b0;
                            win_valid_s = 1'b1;
                        end else begin
                            nb_s       = nxt_nb_s;
                            mem_addr_s = nb_addr(nxt_nb_s, cnt_addr_s);
                        end
                    end else begin
                        state_s = FETCH;
                    end
                end
                PRESENT: begin
                    if (win_ready) begin
                        win_valid_s = 1'b0;
                        if (is_last_s) begin
                            state_s = DONE;
                            done_s  = 1'b1;
                        end else begin
                            state_s    = FETCH;
                            nb_s       = NB_P5;
                            cnt_adv_s  = 1'b1;
                            mem_req_s  = 1'b1;
                            mem_addr_s = cnt_addr_s + ONE_A;
                        end
                    end else begin
                        state_s = PRESENT;
                    end
                end
                DONE: begin
                    state_s   = IDLE;
                    busy_s    = 1'b0;
                    cnt_clr_s = 1'b1;
                end
                default: begin
                    state_s     = IDLE;
                    mem_req_s   = 1'b0;
                    win_valid_s = 1'b0;
                    busy_s      = 1'b0;
                    cnt_clr_s   = 1'b1;
                end
            endcase
        end
    end

    // FSM state and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            nb_r        <= NB_P5;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            win_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            nb_r        <= nb_s;
            mem_req_r   <= mem_req_s;
            mem_addr_r  <= mem_addr_s;
            win_valid_r <= win_valid_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    // Window registers: the centre read seeds all five so border neighbours keep p5.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p2_r <= 8'd0;
            p4_r <= 8'd0;
            p5_r <= 8'd0;
            p6_r <= 8'd0;
            p8_r <= 8'd0;
        end else if (cap_s) begin
            case (nb_r)
                NB_P5: begin
                    p2_r <= mem_rdata;
                    p4_r <= mem_rdata;
                    p5_r <= mem_rdata;
                    p6_r <= mem_rdata;
                    p8_r <= mem_rdata;
                end
                NB_P2:   p2_r <= mem_rdata;
                NB_P4:   p4_r <= mem_rdata;
                NB_P6:   p6_r <= mem_rdata;
                NB_P8:   p8_r <= mem_rdata;
                default: p5_r <= p5_r;
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;
    assign win_valid = win_valid_r;
    assign p2        = p2_r;
    assign p4        = p4_r;
    assign p5        = p5_r;
    assign p6        = p6_r;
    assign p8        = p8_r;

endmodule

// File: tb/tb_gradient_window_sequencer.sv
// Self-checking bench for gradient_window_sequencer on a 4x3 image whose
// memory holds address*10. A reference model derives reads and windows
// from the scan/border rules with plain arithmetic.
module tb_gradient_window_sequencer;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int ADDR_W = 16;
    localparam int BASE   = 0;
    localparam int NPIX   = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              rst, start, abort, busy, done;
    logic              mem_req, mem_ack, win_valid, win_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata, p2, p4, p5, p6, p8;
    logic [1:0]        win_row, win_col;

    gradient_window_sequencer #(
        .IMG_W (IMG_W), .IMG_H (IMG_H), .ADDR_W (ADDR_W), .BASE (BASE)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .abort (abort),
        .busy (busy), .done (done),
        .mem_req (mem_req), .mem_addr (mem_addr), .mem_ack (mem_ack), .mem_rdata (mem_rdata),
        .win_valid (win_valid), .win_ready (win_ready),
        .p2 (p2), .p4 (p4), .p5 (p5), .p6 (p6), .p8 (p8),
        .win_row (win_row), .win_col (win_col)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int lat_mode, rdy_mode, hold_k, hold_left, win_k, done_cnt, wait_left;
    bit pend, junk_ack;
    int pend_addr;
    int reads_q[$];
    int exp_reads[$];
    int got_p[NPIX][5];
    int got_row[NPIX];
    int got_col[NPIX];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: pixel value at (r,c) and the expected window for scan index k.
    function automatic int pix(input int r, input int c);
        return (BASE + r * IMG_W + c) * 10;
    endfunction

    function automatic void exp_window(input int k, output int e[5]);
        int r, c;
        r = k / IMG_W;
        c = k % IMG_W;
        e[2] = pix(r, c);
        e[0] = (r > 0)         ? pix(r - 1, c) : e[2];
        e[1] = (c > 0)         ? pix(r, c - 1) : e[2];
        e[3] = (c < IMG_W - 1) ? pix(r, c + 1) : e[2];
        e[4] = (r < IMG_H - 1) ? pix(r + 1, c) : e[2];
    endfunction

    function automatic int rd(input int i);
        return (i < reads_q.size()) ? reads_q[i] : -1;
    endfunction

    // One clock: respond to memory, drive ready, record handshakes; runs from negedge to negedge.
    task automatic cyc();
        int e[5];
        if (mem_req) begin
            if (pend) chk("mem_addr_stable", 32'(mem_addr), 32'(pend_addr));
            else begin
                pend      = 1'b1;
                pend_addr = int'(mem_addr);
                wait_left = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
            end
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'(int'(mem_addr) * 10);
                pend      = 1'b0;
                if (!abort) reads_q.push_back(int'(mem_addr));
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                wait_left--;
            end
        end else begin
            pend      = 1'b0;
            mem_ack   = junk_ack ? 1'($urandom) : 1'b0;
            mem_rdata = 8'($urandom);
        end
        if (win_valid && hold_k == win_k && hold_left > 0) begin
            win_ready = 1'b0;
            exp_window(win_k, e);
            chk("hold_p2", 32'(p2), 32'(e[0]));
            chk("hold_p5", 32'(p5), 32'(e[2]));
            chk("hold_p8", 32'(p8), 32'(e[4]));
            chk("hold_row", 32'(win_row), 32'(win_k / IMG_W));
            chk("hold_col", 32'(win_col), 32'(win_k % IMG_W));
            chk("hold_mem_req", 32'(mem_req), 32'd0);
            hold_left--;
        end else begin
            win_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom) : 1'b0;
        end
        if (win_valid && win_ready && !abort) begin
            if (win_k < NPIX) begin
                got_p[win_k][0] = int'(p2);
                got_p[win_k][1] = int'(p4);
                got_p[win_k][2] = int'(p5);
                got_p[win_k][3] = int'(p6);
                got_p[win_k][4] = int'(p8);
                got_row[win_k]  = int'(win_row);
                got_col[win_k]  = int'(win_col);
            end
            win_k++;
        end
        if (done) done_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_win_valid"}, 32'(win_valid), 32'd0);
        chk({tag, "_pix"}, 32'({p2, p4, p5, p6}), 32'd0);
        chk({tag, "_p8"}, 32'(p8), 32'd0);
        chk({tag, "_row"}, 32'(win_row), 32'd0);
        chk({tag, "_col"}, 32'(win_col), 32'd0);
    endtask

    task automatic run_frame(input int lm, input int rm, input int hk, input bit mid_start);
        int n;
        lat_mode = lm; rdy_mode = rm; hold_k = hk; hold_left = 7;
        win_k = 0; done_cnt = 0; reads_q.delete();
        for (int k = 0; k < NPIX; k++) begin
            for (int j = 0; j < 5; j++) got_p[k][j] = -1;
            got_row[k] = -1; got_col[k] = -1;
        end
        start = 1'b1; cyc(); start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 2000) begin
            start = mid_start && (n == 20);
            cyc();
            n++;
        end
        start = 1'b0;
        chk("frame_timeout", 32'(n < 2000), 32'd1);
        chk("after_done_busy", 32'(busy), 32'd0);
        chk("after_done_done", 32'(done), 32'd0);
        repeat (3) cyc();
        chk("done_pulses", 32'(done_cnt), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        int e[5];
        int a;
        exp_reads.delete();
        for (int k = 0; k < NPIX; k++) begin
            a = BASE + k;
            exp_reads.push_back(a);
            if (k / IMG_W > 0)         exp_reads.push_back(a - IMG_W);
            if (k % IMG_W > 0)         exp_reads.push_back(a - 1);
            if (k % IMG_W < IMG_W - 1) exp_reads.push_back(a + 1);
            if (k / IMG_W < IMG_H - 1) exp_reads.push_back(a + IMG_W);
        end
        chk({tag, "_read_count"}, 32'(reads_q.size()), 32'(exp_reads.size()));
        for (int i = 0; i < exp_reads.size(); i++)
            chk($sformatf("%s_read%0d", tag, i), 32'(rd(i)), 32'(exp_reads[i]));
        chk({tag, "_win_count"}, 32'(win_k), 32'(NPIX));
        for (int k = 0; k < NPIX; k++) begin
            exp_window(k, e);
            for (int j = 0; j < 5; j++)
                chk($sformatf("%s_w%0d_p%0d", tag, k, j), 32'(got_p[k][j]), 32'(e[j]));
            chk($sformatf("%s_w%0d_row", tag, k), 32'(got_row[k]), 32'(k / IMG_W));
            chk($sformatf("%s_w%0d_col", tag, k), 32'(got_col[k]), 32'(k % IMG_W));
        end
    endtask

    task automatic check_interior(input string tag);
        chk({tag, "_p2"}, 32'(got_p[5][0]), 32'd10);
        chk({tag, "_p4"}, 32'(got_p[5][1]), 32'd40);
        chk({tag, "_p5"}, 32'(got_p[5][2]), 32'd50);
        chk({tag, "_p6"}, 32'(got_p[5][3]), 32'd60);
        chk({tag, "_p8"}, 32'(got_p[5][4]), 32'd90);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mem_ack = 1'b0; mem_rdata = 8'd0;
        win_ready = 1'b0; junk_ack = 1'b0; pend = 1'b0; wait_left = 0; pend_addr = 0;
        lat_mode = 0; rdy_mode = 2; hold_k = -1; hold_left = 0; win_k = 0; done_cnt = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Reset while a window is being presented.
        start = 1'b1; cyc(); start = 1'b0;
        n = 0;
        while (!win_valid && n < 20) begin cyc(); n++; end
        chk("t1_reach_present", 32'(win_valid), 32'd1);
        #2 rst = 1'b1;
        #1 chk_zero("t1_async_rst");
        @(negedge clk);
        rst = 1'b0; pend = 1'b0;
        @(negedge clk);

        // Corner (0,0) with same-cycle ack: valid on the 4th cycle after start.
        reads_q.delete(); lat_mode = 0; rdy_mode = 2;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t2_valid_cycle%0d", i), 32'(win_valid), 32'(i == 4));
            if (i < 4) cyc();
        end
        chk("t2_reads", 32'(reads_q.size()), 32'd3);
        chk("t2_read0", 32'(rd(0)), 32'd0);
        chk("t2_read1", 32'(rd(1)), 32'd1);
        chk("t2_read2", 32'(rd(2)), 32'd4);
        chk("t2_window", 32'({p2, p4, p5, p6}), {8'd0, 8'd0, 8'd0, 8'd10});
        chk("t2_p8", 32'(p8), 32'd40);
        chk("t2_rowcol", 32'({win_row, win_col}), 32'd0);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("t2_abort_busy", 32'(busy), 32'd0);
        chk("t2_abort_valid", 32'(win_valid), 32'd0);

        // Full frame with 7-cycle backpressure at (1,2).
        run_frame(0, 0, 6, 1'b0);
        check_frame("t4");
        check_interior("t4_int");

        // Every read stalled 3 cycles.
        run_frame(3, 0, -1, 1'b0);
        check_frame("t5");
        check_interior("t5_int");

        // Random latency/ready, stray acks while idle, start while busy.
        junk_ack = 1'b1;
        run_frame(-1, 1, -1, 1'b1);
        junk_ack = 1'b0;
        check_frame("t6");

        // Abort during FETCH of window 2, then late acks while idle.
        lat_mode = 2; rdy_mode = 0; hold_k = -1; win_k = 0; done_cnt = 0;
        start = 1'b1; cyc(); start = 1'b0;
        n = 0;
        while (!(win_k == 2 && mem_req && busy) && n < 200) begin cyc(); n++; end
        chk("abort_reach_fetch", 32'(n < 200), 32'd1);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_valid", 32'(win_valid), 32'd0);
        chk("abort_rowcol", 32'({win_row, win_col}), 32'd0);
        junk_ack = 1'b1;
        repeat (6) cyc();
        junk_ack = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_req", 32'(mem_req), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Frame after abort restarts from pixel 0.
        run_frame(0, 0, -1, 1'b0);
        check_frame("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
